// File: rtl/crypto_uart_ctrl.sv
// crypto_uart_ctrl: gathers 16 UART bytes into a 128-bit block, starts the
// cipher core, then streams the 128-bit result back out MSB-first.
// Optional RX inter-byte timeout is compiled in with CRYPTO_CTRL_TIMEOUT_EN.
// Handshakes: rx_valid is a one-cycle strobe with no backpressure (bytes
// arriving outside S_RX are dropped); the tx side transfers a byte on every
// rising edge where tx_valid & tx_ready, and tx_data/tx_valid hold while
// tx_ready is low.
module crypto_uart_ctrl #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic [127:0] cipher_in,
    output logic         cipher_start,
    input  logic         cipher_done,
    input  logic [127:0] cipher_out,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic         busy,
    output logic         rx_drop,
    output logic         rx_timeout,
    output logic [1:0]   o_dbg_state
);

    typedef enum logic [1:0] {
        S_RX    = 2'd0,
        S_START = 2'd1,
        S_BUSY  = 2'd2,
        S_TX    = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [3:0]     r_cnt;
    logic [127:0]   r_cipher_in;
    logic [127:0]   r_obuf;
    logic           r_rx_drop;
    logic           w_rx_accept;
    logic           w_tx_xfer;
    logic           w_done_take;
    logic           w_tmo_expire;
    logic [6:0]     w_byte_lsb;

    // TIMEOUT_CYCLES below 2 cannot express a meaningful idle window.
    if (TIMEOUT_CYCLES < 2) begin : g_timeout_cycles_illegal
    end

    assign w_rx_accept = (r_state == S_RX) && rx_valid;
    assign w_tx_xfer   = (r_state == S_TX) && tx_ready;
    assign w_done_take = (r_state == S_BUSY) && cipher_done;
    // Byte k of the block (k = cnt) lands at bits [127-8k -: 8]; ~cnt == 15-cnt.
    assign w_byte_lsb  = {~r_cnt, 3'b000};

    assign cipher_in    = r_cipher_in;
    assign cipher_start = (r_state == S_START);
    assign busy         = (r_state != S_RX);
    assign tx_valid     = (r_state == S_TX);
    assign tx_data      = r_obuf[127:120];
    assign rx_drop      = r_rx_drop;
    assign o_dbg_state  = r_state;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_RX;
        else        r_state <= w_state_nxt;
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RX:    if (w_rx_accept && (r_cnt == 4'd15)) w_state_nxt = S_START;
            S_START: w_state_nxt = S_BUSY;
            S_BUSY:  if (cipher_done) w_state_nxt = S_TX;
            S_TX:    if (w_tx_xfer && (r_cnt == 4'd15)) w_state_nxt = S_RX;
            default: w_state_nxt = S_RX;
        endcase
    end

    // Byte counter: counts received bytes in S_RX and sent bytes in S_TX;
    // it only wraps on the 16th byte of either phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            r_cnt <= 4'd0;
        else if (w_rx_accept)  r_cnt <= r_cnt + 4'd1;
        else if (w_tmo_expire) r_cnt <= 4'd0;
        else if (w_tx_xfer)    r_cnt <= r_cnt + 4'd1;
    end

    // Plaintext assembly; untouched between the 16th byte and the next block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            r_cipher_in <= '0;
        else if (w_rx_accept)  r_cipher_in[w_byte_lsb +: 8] <= rx_data;
        else if (w_tmo_expire) r_cipher_in <= '0;
    end

    // Ciphertext buffer, shifted left one byte per tx transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           r_obuf <= '0;
        else if (w_done_take) r_obuf <= cipher_out;
        else if (w_tx_xfer)   r_obuf <= {r_obuf[119:0], 8'h00};
    end

    // Drop flag for bytes that arrive while a block is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rx_drop <= 1'b0;
        else        r_rx_drop <= rx_valid && (r_state != S_RX);
    end

`ifdef CRYPTO_CTRL_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TW-1:0] r_tmo;
    logic          r_rx_timeout;

    // Expiry only on an idle cycle: a byte in the same cycle takes priority.
    assign w_tmo_expire = (r_state == S_RX) && (r_cnt != 4'd0) && !rx_valid &&
                          (r_tmo == TW'(TIMEOUT_CYCLES - 1));
    assign rx_timeout   = r_rx_timeout;

    // Idle-cycle counter for a partially received block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo <= '0;
        end else if (rx_valid || (r_state != S_RX) || (r_cnt == 4'd0) || w_tmo_expire) begin
            r_tmo <= '0;
        end else begin
            r_tmo <= r_tmo + 1'b1;
        end
    end

    // One-cycle pulse when a partial block is discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rx_timeout <= 1'b0;
        else        r_rx_timeout <= w_tmo_expire;
    end
`else
    assign w_tmo_expire = 1'b0;
    assign rx_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_crypto_uart_ctrl.sv
// Bench for crypto_uart_ctrl: random blocks checked against a byte-queue
// reference (16 bytes in -> packed block; cipher result -> 16 bytes out).
// Inputs are driven and outputs sampled on the falling edge.
module tb_crypto_uart_ctrl;

  logic         clk;
  logic         rst_n;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic [127:0] cipher_in;
  logic         cipher_start;
  logic         cipher_done;
  logic [127:0] cipher_out;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic         busy;
  logic         rx_drop;
  logic         rx_timeout;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] blk[16];
  logic [7:0] exp_q[$];

  crypto_uart_ctrl #(.TIMEOUT_CYCLES(1000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .cipher_in    (cipher_in),
    .cipher_start (cipher_start),
    .cipher_done  (cipher_done),
    .cipher_out   (cipher_out),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .busy         (busy),
    .rx_drop      (rx_drop),
    .rx_timeout   (rx_timeout),
    .o_dbg_state  (dbg_state)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got time limit reached, need $finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h need %h", tag, got, exp);
  endtask

  function automatic logic [127:0] pack_blk();
    logic [127:0] v = '0;
    for (int i = 0; i < 16; i++) v = {v[119:0], blk[i]};
    return v;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 16; i++) blk[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic fill_count();
    for (int i = 0; i < 16; i++) blk[i] = 8'(i);
  endtask

  // driver: one byte strobe after a random gap; returns on the falling
  // edge right after the byte was taken
  task automatic send_byte(input logic [7:0] b);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom_range(0, 255));
  endtask

  task automatic send_range(input int from, input int to);
    for (int i = from; i <= to; i++) send_byte(blk[i]);
  endtask

  // tx collector: pops exp_q per transfer; optional long stall and reset
  task automatic collect(input int stall_after, input int abort_after);
    int   sent = 0;
    int   budget = 0;
    bit   stalled = 0;
    bit   ok;
    logic v;
    logic r;
    logic [7:0] d;
    while (exp_q.size() > 0 && budget < 4000) begin
      if (abort_after >= 0 && sent == abort_after) begin
        rst_n = 1'b0;
        #1;
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_cipher_in", cipher_in, 0);
        check("rst_start_drop_tmo", {cipher_start, rx_drop, rx_timeout}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tx_ready = 1'b1;
        ok = 1;
        repeat (30) begin
          @(negedge clk);
          if (tx_valid || cipher_start || busy) ok = 0;
        end
        tx_ready = 1'b0;
        check("post_rst_quiet", ok, 1);
        exp_q.delete();
        return;
      end
      if (stall_after >= 0 && sent == stall_after && !stalled) begin
        stalled = 1;
        tx_ready = 1'b0;
        ok = 1;
        repeat (100) begin
          @(negedge clk);
          budget++;
          if (!(tx_valid === 1'b1 && tx_data === exp_q[0])) ok = 0;
        end
        check("tx_hold", ok, 1);
      end
      tx_ready = ($urandom_range(0, 3) != 0);
      v = tx_valid;
      r = tx_ready;
      d = tx_data;
      @(negedge clk);
      budget++;
      if (v && r) begin
        check("tx_byte", d, exp_q.pop_front());
        sent++;
      end
    end
    tx_ready = 1'b0;
    if (budget >= 4000) check("tx_budget", 0, 1);
    check("tx_idle_after", tx_valid, 0);
    check("busy_after", busy, 0);
  endtask

  // scoreboard for one block whose 16th byte was just accepted
  task automatic process_block(input logic [127:0] exp_in, input int stall_after,
                               input int abort_after, input bit drop_in_busy);
    logic [127:0] co;
    check("start_pulse", cipher_start, 1);
    check("cipher_in", cipher_in, exp_in);
    check("busy_start", busy, 1);
    @(negedge clk);
    check("start_one_cycle", cipher_start, 0);
    if (drop_in_busy) begin
      rx_data  = 8'hAA;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      check("rx_drop", rx_drop, 1);
      @(negedge clk);
      check("rx_drop_once", rx_drop, 0);
    end
    repeat ($urandom_range(0, 8)) @(negedge clk);
    check("no_tx_in_busy", tx_valid, 0);
    co = {$urandom, $urandom, $urandom, $urandom};
    cipher_done = 1'b1;
    cipher_out  = co;
    @(negedge clk);
    cipher_done = 1'b0;
    cipher_out  = {$urandom, $urandom, $urandom, $urandom};
    check("tx_first", {tx_valid, tx_data}, {1'b1, co[127:120]});
    check("cipher_in_hold", cipher_in, exp_in);
    for (int i = 0; i < 16; i++) exp_q.push_back(co[127 - 8*i -: 8]);
    collect(stall_after, abort_after);
  endtask

  initial begin
    int pulses;
    int first_idx;
    rst_n       = 1'b0;
    rx_data     = 8'h00;
    rx_valid    = 1'b0;
    cipher_done = 1'b0;
    cipher_out  = '0;
    tx_ready    = 1'b0;
    #1;
    check("reset_outs", {cipher_start, tx_valid, tx_data, busy, rx_drop, rx_timeout}, 0);
    check("reset_cipher_in", cipher_in, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // counting block 0x00..0x0F
    fill_count();
    send_range(0, 15);
    process_block(128'h000102030405060708090A0B0C0D0E0F, -1, -1, 0);

    // long tx stall after the fifth byte
    fill_random();
    send_range(0, 15);
    process_block(pack_blk(), 5, -1, 0);

    // byte during BUSY is dropped; next block comes only from later bytes
    fill_random();
    send_range(0, 15);
    process_block(pack_blk(), -1, -1, 1);
    fill_random();
    send_range(0, 15);
    process_block(pack_blk(), -1, -1, 0);

    // stray cipher_done while receiving (cnt = 3)
    fill_random();
    send_range(0, 2);
    cipher_done = 1'b1;
    cipher_out  = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    cipher_done = 1'b0;
    check("stray_done_no_tx", {tx_valid, busy}, 0);
    @(negedge clk);
    check("stray_done_no_tx2", tx_valid, 0);
    send_range(3, 15);
    process_block(pack_blk(), -1, -1, 0);

    // idle gap after a partial block
    fill_random();
    send_range(0, 4);
    pulses = 0;
    first_idx = -1;
    for (int i = 1; i <= 1010; i++) begin
      @(negedge clk);
      if (rx_timeout) begin
        pulses++;
        if (first_idx < 0) first_idx = i;
      end
    end
`ifdef CRYPTO_CTRL_TIMEOUT_EN
    check("timeout_pulses", pulses, 1);
    check("timeout_when", first_idx, 1000);
    check("timeout_clears", cipher_in, 0);
    fill_random();
    send_range(0, 15);
`else
    check("timeout_pulses", pulses, 0);
    send_range(5, 15);
`endif
    process_block(pack_blk(), -1, -1, 0);

    // reset while byte 8 is on tx, then a clean counting block
    fill_random();
    send_range(0, 15);
    process_block(pack_blk(), -1, 7, 0);
    fill_count();
    send_range(0, 15);
    process_block(128'h000102030405060708090A0B0C0D0E0F, -1, -1, 0);

    // a few more random blocks
    for (int k = 0; k < 3; k++) begin
      fill_random();
      send_range(0, 15);
      process_block(pack_blk(), -1, -1, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
